// File: rtl/coin_bank.sv
// Credit accumulator with per-channel coin edge detection, ceiling rejection and greedy change payout.
// Optional build macro COIN_BANK_SYNC_EN adds a 2-flop synchroniser on every coin_in bit.
module coin_bank #(
  parameter int                         NUM_COINS    = 3,
  parameter int                         CREDIT_W     = 8,
  parameter logic [8*NUM_COINS-1:0]     COIN_VALUES  = {8'd25, 8'd10, 8'd5},
  parameter int                         MAX_CREDIT   = 200,
  parameter int                         DISPENSE_GAP = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] coin_in,
  input  logic [CREDIT_W-1:0]  price,
  input  logic                 vend_req,
  input  logic                 refund_req,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 vend_ok,
  output logic                 vend_fail,
  output logic [NUM_COINS-1:0] coin_reject,
  output logic [NUM_COINS-1:0] change_out,
  output logic                 busy
);

  localparam int SW = CREDIT_W + 2;
  localparam int GW = (DISPENSE_GAP > 1) ? $clog2(DISPENSE_GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(DISPENSE_GAP - 1);
  localparam logic [SW-1:0] MAX_S      = SW'(MAX_CREDIT);

  typedef enum logic {IDLE, DISPENSE} state_t;

  state_t                state, state_n;
  logic [CREDIT_W-1:0]   credit_n, remaining, remaining_n, rem_next;
  logic [GW-1:0]         gap, gap_n;
  logic [NUM_COINS-1:0]  coin_s, hist, det;
  logic [NUM_COINS-1:0]  rej_n, chg_n;
  logic                  ok_n, fail_n, found;
  logic [SW-1:0]         run, pick_val;
  int                    pick;

  function automatic logic [SW-1:0] coin_val(input int i);
    return SW'(COIN_VALUES[8*i +: 8]);
  endfunction

`ifdef COIN_BANK_SYNC_EN
  logic [NUM_COINS-1:0] sync1, sync2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= coin_in;
      sync2 <= sync1;
    end
  end
  assign coin_s = sync2;
`else
  assign coin_s = coin_in;
`endif

  // History resets high so a coin held across reset release is not an edge.
  assign det  = coin_s & ~hist;
  assign busy = (state == DISPENSE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hist        <= '1;
      credit      <= '0;
      remaining   <= '0;
      gap         <= '0;
      vend_ok     <= 1'b0;
      vend_fail   <= 1'b0;
      coin_reject <= '0;
      change_out  <= '0;
    end else begin
      state       <= state_n;
      hist        <= coin_s;
      credit      <= credit_n;
      remaining   <= remaining_n;
      gap         <= gap_n;
      vend_ok     <= ok_n;
      vend_fail   <= fail_n;
      coin_reject <= rej_n;
      change_out  <= chg_n;
    end
  end

  always_comb begin
    state_n     = state;
    credit_n    = credit;
    remaining_n = remaining;
    gap_n       = gap;
    ok_n        = 1'b0;
    fail_n      = 1'b0;
    rej_n       = '0;
    chg_n       = '0;
    run         = '0;
    pick        = 0;
    pick_val    = '0;
    found       = 1'b0;
    rem_next    = '0;
    case (state)
      IDLE: begin
        if (refund_req) begin
          rej_n = det;
          if (credit != '0) begin
            remaining_n = credit;
            credit_n    = '0;
            gap_n       = '0;
            state_n     = DISPENSE;
          end
        end else if (vend_req) begin
          rej_n = det;
          if (credit >= price) begin
            ok_n        = 1'b1;
            remaining_n = credit - price;
            credit_n    = '0;
            gap_n       = '0;
            if (credit != price) state_n = DISPENSE;
          end else begin
            fail_n = 1'b1;
          end
        end else begin
          // Lower channels claim headroom first; the running sum cannot wrap.
          run = SW'(credit);
          for (int i = 0; i < NUM_COINS; i++) begin
            if (det[i]) begin
              if (run + coin_val(i) <= MAX_S) run = run + coin_val(i);
              else rej_n[i] = 1'b1;
            end
          end
          credit_n = run[CREDIT_W-1:0];
        end
      end
      DISPENSE: begin
        rej_n = det;
        if (gap == '0) begin
          for (int i = 0; i < NUM_COINS; i++) begin
            if (coin_val(i) <= SW'(remaining)) begin
              pick  = i;
              found = 1'b1;
            end
          end
          if (found) begin
            pick_val = coin_val(pick);
            rem_next = CREDIT_W'(SW'(remaining) - pick_val);
            for (int i = 0; i < NUM_COINS; i++) begin
              if (i == pick) chg_n[i] = 1'b1;
            end
            remaining_n = rem_next;
            gap_n       = GAP_RELOAD;
            if (SW'(rem_next) < coin_val(0)) begin
              state_n     = IDLE;
              credit_n    = rem_next;
              remaining_n = '0;
              gap_n       = '0;
            end
          end else begin
            // Residue below the smallest coin stays as credit.
            state_n     = IDLE;
            credit_n    = remaining;
            remaining_n = '0;
            gap_n       = '0;
          end
        end else begin
          gap_n = gap - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coin_bank.sv
// Bench for coin_bank: coin vector table, hand-written payout/reset sequences, randomized run vs reference model.
module tb_coin_bank;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] coin_in;
  logic [7:0] price;
  logic       vend_req, refund_req;
  logic [7:0] credit;
  logic       vend_ok, vend_fail, busy;
  logic [2:0] coin_reject, change_out;

  int total = 0;
  int bad   = 0;

  coin_bank dut (
    .clk(clk), .reset(reset), .coin_in(coin_in), .price(price),
    .vend_req(vend_req), .refund_req(refund_req), .credit(credit),
    .vend_ok(vend_ok), .vend_fail(vend_fail), .coin_reject(coin_reject),
    .change_out(change_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; coin_in = '0; vend_req = 1'b0; refund_req = 1'b0; price = '0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic pulse_coin(input logic [2:0] c);
    coin_in = c;
    step();
    coin_in = '0;
    step();
  endtask

  typedef struct {
    logic [2:0] coin;
    logic [7:0] exp_credit;
    logic [2:0] exp_rej;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int          vals[3] = '{5, 10, 25};
  logic [2:0]  m_prev;
  int          m_credit;
  int          m_resid;
  logic [2:0]  m_q[$];

  task automatic build(input int r);
    logic [2:0] coins[$];
    for (int i = 2; i >= 0; i--) begin
      while (r >= vals[i]) begin
        coins.push_back(3'(1 << i));
        r -= vals[i];
      end
    end
    m_resid = r;
    if (coins.size() == 0) m_q.push_back(3'b000);
    foreach (coins[j]) begin
      m_q.push_back(coins[j]);
      if (j != coins.size() - 1)
        for (int g = 0; g < GAP - 1; g++) m_q.push_back(3'b000);
    end
  endtask

  logic [2:0] exp_chg[7] = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001};
  logic       exp_bsy[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [2:0] c, det, e_rej, e_chg;
    logic       rq, vq, e_ok, e_fail;
    int         p;

    // Reset state
    do_reset();
    check("reset_credit", credit, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {vend_ok, vend_fail, coin_reject, change_out}, 0);

    // Coin table: single edges, held level, simultaneous edges, ceiling rejects
    vecs.push_back('{3'b100, 8'd25, 3'b000});
    vecs.push_back('{3'b000, 8'd25, 3'b000});
    vecs.push_back('{3'b010, 8'd35, 3'b000});
    vecs.push_back('{3'b000, 8'd35, 3'b000});
    vecs.push_back('{3'b001, 8'd40, 3'b000});
    vecs.push_back('{3'b000, 8'd40, 3'b000});
    for (int i = 0; i < 10; i++) vecs.push_back('{3'b010, 8'd50, 3'b000});
    vecs.push_back('{3'b000, 8'd50, 3'b000});
    vecs.push_back('{3'b101, 8'd80, 3'b000});
    for (int i = 0; i < 4; i++) begin
      vecs.push_back('{3'b000, 8'(80 + 25 * i), 3'b000});
      vecs.push_back('{3'b100, 8'(105 + 25 * i), 3'b000});
    end
    vecs.push_back('{3'b000, 8'd180, 3'b000});
    vecs.push_back('{3'b010, 8'd190, 3'b000});
    vecs.push_back('{3'b000, 8'd190, 3'b000});
    vecs.push_back('{3'b100, 8'd190, 3'b100});
    vecs.push_back('{3'b000, 8'd190, 3'b000});
    vecs.push_back('{3'b010, 8'd200, 3'b000});
    vecs.push_back('{3'b000, 8'd200, 3'b000});
    vecs.push_back('{3'b001, 8'd200, 3'b001});
    vecs.push_back('{3'b000, 8'd200, 3'b000});
    foreach (vecs[i]) begin
      coin_in = vecs[i].coin;
      step();
      check($sformatf("vec%0d_credit", i), credit, vecs[i].exp_credit);
      check($sformatf("vec%0d_reject", i), coin_reject, vecs[i].exp_rej);
    end

    // Simultaneous edges from zero credit
    do_reset();
    coin_in = 3'b101;
    step();
    check("simul_credit", credit, 30);
    check("simul_reject", coin_reject, 0);
    coin_in = '0;
    step();

    // Vend 35 from 100: payout 25,25,10,5
    do_reset();
    for (int i = 0; i < 4; i++) pulse_coin(3'b100);
    check("vend_pre_credit", credit, 100);
    price = 8'd35; vend_req = 1'b1;
    step();
    vend_req = 1'b0;
    check("vend_ok", vend_ok, 1);
    check("vend_busy", busy, 1);
    check("vend_credit0", credit, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("payout%0d_chg", i), change_out, exp_chg[i]);
      check($sformatf("payout%0d_busy", i), busy, exp_bsy[i]);
    end
    step();
    check("payout_end_credit", credit, 0);
    check("payout_end_chg", change_out, 0);

    // Vend fail then refund beating vend
    do_reset();
    pulse_coin(3'b100);
    pulse_coin(3'b001);
    price = 8'd35; vend_req = 1'b1;
    step();
    vend_req = 1'b0;
    check("fail_pulse", {vend_ok, vend_fail}, 2'b01);
    check("fail_credit", credit, 30);
    check("fail_busy", busy, 0);
    step();
    price = 8'd10; vend_req = 1'b1; refund_req = 1'b1;
    step();
    vend_req = 1'b0; refund_req = 1'b0;
    check("refund_no_vend", {vend_ok, vend_fail}, 0);
    check("refund_busy", busy, 1);
    step();
    check("refund_chg0", change_out, 3'b100);
    step();
    check("refund_gap", change_out, 0);
    step();
    check("refund_chg1", change_out, 3'b001);
    check("refund_busy_end", busy, 0);
    check("refund_credit", credit, 0);

    // Reset mid-payout with a coin held across release
    do_reset();
    pulse_coin(3'b100);
    pulse_coin(3'b100);
    pulse_coin(3'b010);
    pulse_coin(3'b001);
    check("abort_pre_credit", credit, 65);
    refund_req = 1'b1;
    step();
    refund_req = 1'b0;
    step();
    check("abort_first_chg", change_out, 3'b100);
    coin_in = 3'b001;
    #2 reset = 1'b1;
    #1;
    check("abort_async", {credit, vend_ok, vend_fail, coin_reject, change_out, busy}, 0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("abort_after%0d", i), {credit, change_out, busy}, 0);
    end
    coin_in = '0;

    // Randomized run against the reference model
    do_reset();
    m_prev = 3'b000; m_credit = 0; m_resid = 0; m_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      c  = 3'($urandom_range(0, 7));
      rq = ($urandom_range(0, 15) == 0);
      vq = ($urandom_range(0, 9) == 0);
      p  = $urandom_range(0, 120);
      coin_in = c; refund_req = rq; vend_req = vq; price = 8'(p);
      det = c & ~m_prev;
      m_prev = c;
      e_rej = '0; e_ok = 1'b0; e_fail = 1'b0; e_chg = '0;
      if (m_q.size() > 0) begin
        e_rej = det;
        e_chg = m_q.pop_front();
        if (m_q.size() == 0) m_credit = m_resid;
      end else if (rq || vq) begin
        e_rej = det;
        if (rq) begin
          if (m_credit != 0) begin
            build(m_credit);
            m_credit = 0;
          end
        end else if (m_credit >= p) begin
          e_ok = 1'b1;
          if (m_credit - p != 0) build(m_credit - p);
          m_credit = 0;
        end else begin
          e_fail = 1'b1;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (det[i]) begin
            if (m_credit + vals[i] <= 200) m_credit += vals[i];
            else e_rej[i] = 1'b1;
          end
        end
      end
      step();
      check("rnd_credit", credit, m_credit);
      check("rnd_ok_fail", {vend_ok, vend_fail}, {e_ok, e_fail});
      check("rnd_reject", coin_reject, e_rej);
      check("rnd_change", change_out, e_chg);
      check("rnd_busy", busy, (m_q.size() > 0));
    end
    coin_in = '0; vend_req = 1'b0; refund_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/coin_bank.md
# coin_bank

Parameterised credit accumulator and change dispenser for the vending datapath. Detects rising edges on any number of coin channels, each with its own denomination, and accumulates credit with a hard ceiling, rejecting coins that would exceed it. Serves vend and refund requests from the vend controller. Pays change out greedily, one coin pulse at a time, to the coin-return driver.

## Interface
- NUM_COINS, 3: number of coin channels/denominations.
- CREDIT_W, 8: credit and price width.
- COIN_VALUES, {8'd25,8'd10,8'd5}: packed 8-bit denominations. Entry i is bits [8i+7:8i]. Entries strictly ascending with index.
- MAX_CREDIT, 200: credit ceiling. Must be < 2^CREDIT_W.
- DISPENSE_GAP, 2: cycles between change pulses. Must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- coin_in  in  NUM_COINS  level per channel; each rising edge is one coin
- price  in  CREDIT_W  item price, sampled with vend_req
- vend_req  in  1  purchase request, evaluated every IDLE cycle it is high
- refund_req  in  1  return all credit, evaluated every IDLE cycle it is high
- credit  out  CREDIT_W  current credit
- vend_ok  out  1  one-cycle pulse: purchase accepted
- vend_fail  out  1  one-cycle pulse: credit < price
- coin_reject  out  NUM_COINS  one-cycle pulse per rejected coin
- change_out  out  NUM_COINS  one-hot one-cycle pulse per dispensed coin
- busy  out  1  high in DISPENSE

## Operation
- Reset: all outputs 0, state IDLE, remaining 0, gap counter 0. Coin history flops are set to all-ones, so a coin held high across reset release is not counted.
- Edge detect: det[i] = coin_in[i] & ~hist[i]. hist is updated every cycle in every state.
- Acceptance (IDLE, no request acted on):
  - Channels are scanned in index order 0→N-1.
  - A coin is accepted if running_credit + value ≤ MAX_CREDIT. Otherwise coin_reject[i] pulses.
  - Simultaneous edges sum.
  - Internal sum width is CREDIT_W+2, so there is no wrap.
- In DISPENSE, or in a cycle where IDLE acts on a request, every detected coin is rejected.
- IDLE requests:
  - refund_req has priority over vend_req.
  - Refund: remaining ← credit, credit ← 0, go to DISPENSE if credit ≠ 0.
  - Vend with credit ≥ price: vend_ok pulses, remaining ← credit − price, credit ← 0, go to DISPENSE if remaining ≠ 0.
  - Vend with credit < price: vend_fail pulses, credit unchanged.
- DISPENSE:
  - When gap counter = 0, pick the highest i with value[i] ≤ remaining.
  - Pulse change_out[i], remaining −= value[i], and reload the gap counter to DISPENSE_GAP−1.
  - Otherwise decrement the gap counter.
  - If the new remaining < value[0], go to IDLE and set credit ← new remaining. Any residue is kept as credit, not lost.
- Reset mid-dispense aborts immediately. No further change pulses.

## Timing
- Without sync: coin_in high at edge k with hist low makes credit/coin_reject valid after edge k. Latency is 1 cycle.
- Request sampled at edge k: vend_ok/vend_fail valid after edge k, and busy rises after edge k.
- First change pulse after edge k+1. Later pulses come every DISPENSE_GAP cycles.
- busy falls at the same edge that registers the final change pulse.
- All outputs are registered.

## Configuration
- COIN_BANK_SYNC_EN defined: each coin_in bit passes through a 2-flop synchroniser before edge detect.
  - Synchroniser flops reset to 1.
  - Coin-to-credit latency becomes 3 cycles.
- Undefined: coin_in feeds edge detect directly. Latency is 1 cycle.

## Test plan
- Separate edges on coin 25, then 10, then 5 from 0 → credit 25, 35, 40. coin_in[1] held high 10 cycles adds 10 exactly once.
- Simultaneous rising coin_in[0] and coin_in[2] at credit 0 → credit 30 in one cycle, no reject.
- Credit 190, coin 25 → coin_reject[2] pulse, credit stays 190. Then coin 10 → credit 200.
- Credit 100, price 35, vend_req at edge k → vend_ok. change_out pulses [2],[2],[1],[0] at k+1, k+3, k+5, k+7. busy falls with the last pulse; credit 0.
- Credit 30, price 35 → vend_fail, credit 30. refund_req and vend_req together → refund wins, change [2] then [0], no vend pulses.
- Reset asserted after the first change pulse of a 65 payout → all outputs 0 immediately, no further pulses. coin_in held high through reset release → credit stays 0.
